// File: rtl/fpu_adder_arbiter.sv
// fpu_adder_arbiter: round-robin sharing of one strobe/ack FP adder among NUM_REQ requesters
module fpu_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_stb,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [31:0]            resp_z,
  output logic [NUM_REQ-1:0]     resp_stb,
  input  logic [NUM_REQ-1:0]     resp_ack,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_a_stb,
  input  logic                   add_a_ack,
  output logic                   add_b_stb,
  input  logic                   add_b_ack,
  input  logic [31:0]            add_z,
  input  logic                   add_z_stb,
  output logic                   add_z_ack,
  output logic                   busy,
  output logic [GRANT_W-1:0]     grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, RESP} state_t;
  state_t state, state_nx;
  logic a_done, b_done, resp_done, found;
  logic [GRANT_W-1:0] pick;
  assign busy = state != IDLE;
  assign add_a_stb = state == ISSUE && !a_done;
  assign add_b_stb = state == ISSUE && !b_done;
  assign resp_stb = (state == RESP && !resp_done) ? NUM_REQ'(1) << grant : '0;
  // round-robin search starting just after the last grant
  always_comb begin
    pick = grant;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_stb[(int'(grant) + i) % NUM_REQ]) begin
        pick = GRANT_W'((int'(grant) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  // next state: an ack seen this cycle counts the same as a registered done flag
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? ISSUE : IDLE;
      ISSUE:   state_nx = ((a_done || add_a_ack) && (b_done || add_b_ack)) ? WAIT_Z : ISSUE;
      WAIT_Z:  state_nx = add_z_stb ? RESP : WAIT_Z;
      RESP:    state_nx = ((resp_done || resp_ack[grant]) && (!add_z_ack || !add_z_stb)) ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // datapath and handshake registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= GRANT_W'(NUM_REQ - 1);
      add_a <= '0;
      add_b <= '0;
      resp_z <= '0;
      req_ack <= '0;
      add_z_ack <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      resp_done <= 1'b0;
    end else begin
      state <= state_nx;
      req_ack <= '0;
      if (state == IDLE && found) begin
        grant <= pick;
        add_a <= req_a[32*pick +: 32];
        add_b <= req_b[32*pick +: 32];
        req_ack <= NUM_REQ'(1) << pick;
        a_done <= 1'b0;
        b_done <= 1'b0;
        resp_done <= 1'b0;
      end
      if (state == ISSUE) begin
        a_done <= a_done || add_a_ack;
        b_done <= b_done || add_b_ack;
      end
      if (state == WAIT_Z && add_z_stb) begin
        resp_z <= add_z;
        add_z_ack <= 1'b1;
      end
      if (state == RESP) begin
        if (!add_z_stb) add_z_ack <= 1'b0;
        if (resp_ack[grant]) resp_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// tb_fpu_adder_arbiter: scoreboard bench with a behavioural adder, requesters and round-robin model
module tb_fpu_adder_arbiter;
  localparam int N = 4;
  localparam logic [31:0] ONE = 32'h3F800000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] req_stb = '1, resp_ack = '0;
  logic [N-1:0] req_ack, resp_stb;
  logic [31:0] resp_z, add_a, add_b;
  logic add_a_stb, add_b_stb, add_z_ack, busy;
  logic add_a_ack = 1'b0, add_b_ack = 1'b0, add_z_stb = 1'b0;
  logic [31:0] add_z = '0;
  logic [$clog2(N)-1:0] grant;
  typedef struct {int idx; logic [31:0] z;} exp_t;
  exp_t exp_q[$];
  int grant_log[$];
  int checks = 0, errors = 0;
  bit hold = 0, slow_z = 0, noise = 0;
  int ack_delay = 0;
  fpu_adder_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack), .add_a(add_a), .add_b(add_b),
    .add_a_stb(add_a_stb), .add_a_ack(add_a_ack), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack), .busy(busy), .grant(grant)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  // adder stand-in: exact sums for the directed cases, an operand-order-sensitive mix otherwise
  function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == ONE && b == ONE) return 32'h40000000;
    if (a == 0 && b == 0) return 32'h0;
    return (a ^ 32'h5A5A5A5A) + (b << 1);
  endfunction
  function automatic int rr_winner(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? ONE : $urandom;
  endfunction
  task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_stb[i] = 1'b1;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (!(!busy && req_stb == 0 && resp_stb == 0 && exp_q.size() == 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(n < 400, name, n, 400);
  endtask
  // behavioural adder: independent random operand acks, random latency, holds z until acked
  initial begin
    logic [31:0] op_a, op_b;
    bit have_a, have_b;
    int z_wait;
    have_a = 0; have_b = 0; z_wait = 0; op_a = 0; op_b = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; have_a = 0; have_b = 0;
      end else begin
        if (add_z_stb && add_z_ack) begin
          add_z_stb = 0; have_a = 0; have_b = 0;
        end else if (have_a && have_b && !add_z_stb) begin
          if (z_wait == 0) begin
            add_z = adder_fn(op_a, op_b);
            add_z_stb = 1;
          end else z_wait--;
        end
        if (add_a_ack) begin
          op_a = add_a; have_a = 1; add_a_ack = 0; z_wait = slow_z ? 40 : $urandom_range(0, 4);
        end else if (add_a_stb && !have_a && $urandom_range(0, 2) == 0) add_a_ack = 1;
        if (add_b_ack) begin
          op_b = add_b; have_b = 1; add_b_ack = 0; z_wait = slow_z ? 40 : $urandom_range(0, 4);
        end else if (add_b_stb && !have_b && $urandom_range(0, 2) == 0) add_b_ack = 1;
      end
    end
  end
  // requesters: drop req_stb once accepted, or reload fresh operands while holding
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        if (hold) begin
          req_a[32*i +: 32] = $urandom;
          req_b[32*i +: 32] = $urandom;
        end else req_stb[i] = 1'b0;
      end
    end
  end
  // result consumers: ack after a delay, occasional stray acks from idle requesters
  initial begin
    int cnt[N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (resp_ack[i]) begin
          resp_ack[i] = 1'b0;
          cnt[i] = 0;
        end else if (resp_stb[i]) begin
          if (cnt[i] >= ((ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay)) resp_ack[i] = 1'b1;
          else cnt[i]++;
        end else if (noise && $urandom_range(0, 7) == 0) resp_ack[i] = 1'b1;
      end
    end
  end
  // monitor: predicts each grant from the pending set, queues the result, checks returned results
  initial begin
    logic [N-1:0] stb_s, prev_ack, prev_resp, exp_ack;
    logic [32*N-1:0] a_s, b_s;
    logic rst_s;
    int model_ptr, w;
    exp_t e;
    prev_ack = '0; prev_resp = '0; model_ptr = N - 1;
    forever begin
      @(posedge clk);
      stb_s = req_stb; a_s = req_a; b_s = req_b; rst_s = rst;
      #1;
      if (!rst_s) begin
        model_ptr = N - 1;
        exp_q.delete();
      end else begin
        if (req_ack != 0) begin
          w = rr_winner(stb_s, model_ptr);
          exp_ack = (w < 0) ? '0 : N'(1) << w;
          check(req_ack == exp_ack, "req_ack_winner", req_ack, exp_ack);
          check(prev_ack == 0, "req_ack_width", prev_ack, 0);
          check(grant == w, "grant_index", grant, w);
          if (w >= 0) begin
            model_ptr = w;
            grant_log.push_back(w);
            exp_q.push_back('{w, adder_fn(a_s[32*w +: 32], b_s[32*w +: 32])});
          end
        end
        if (resp_stb != 0 && prev_resp == 0) begin
          if (exp_q.size() == 0) check(0, "resp_unexpected", resp_stb, 0);
          else begin
            e = exp_q.pop_front();
            check(resp_stb == N'(1) << e.idx, "resp_target", resp_stb, N'(1) << e.idx);
            check(resp_z == e.z, "resp_z", resp_z, e.z);
          end
        end
      end
      prev_ack = req_ack;
      prev_resp = resp_stb;
    end
  end
  // directed scenarios followed by a randomized phase
  initial begin
    logic [31:0] z0;
    int n;
    repeat (2) begin
      @(negedge clk);
      check(req_ack == 0, "t1_req_ack", req_ack, 0);
      check(resp_stb == 0, "t1_resp_stb", resp_stb, 0);
      check({add_a_stb, add_b_stb, add_z_ack, busy} == 0, "t1_ctrl", {add_a_stb, add_b_stb, add_z_ack, busy}, 0);
      check(resp_z == 0 && add_a == 0 && add_b == 0, "t1_data", resp_z | add_a | add_b, 0);
      check(grant == N - 1, "t1_grant", grant, N - 1);
    end
    rst = 1'b1;
    req_stb = '0;
    @(negedge clk);
    post(0, ONE, ONE);
    wait_idle("t2_done");
    check(grant_log.size() == 1 && grant_log[0] == 0, "t2_grants", grant_log.size(), 1);
    grant_log.delete();
    @(negedge clk);
    post(1, 32'h0, 32'h0);
    post(2, ONE, ONE);
    wait_idle("t3_done");
    check(grant_log.size() == 2, "t3_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check(grant_log[0] == 1, "t3_first", grant_log[0], 1);
      check(grant_log[1] == 2, "t3_second", grant_log[1], 2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    grant_log.delete();
    hold = 1;
    for (int i = 0; i < N; i++) post(i, $urandom, $urandom);
    n = 0;
    while (grant_log.size() < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    hold = 0;
    req_stb = '0;
    check(n < 500, "t4_timeout", n, 500);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) check(grant_log[k] == k % N, "t4_order", grant_log[k], k % N);
    wait_idle("t4_done");
    ack_delay = 10;
    post(0, rnd_op(), rnd_op());
    n = 0;
    while (!resp_stb[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(n < 200, "t5_resp_timeout", n, 200);
    z0 = resp_z;
    post(1, rnd_op(), rnd_op());
    repeat (8) begin
      @(negedge clk);
      check(resp_stb[0] == 1'b1, "t5_stb_hold", resp_stb, 1);
      check(resp_z == z0, "t5_z_hold", resp_z, z0);
      check(req_ack == 0, "t5_no_grant", req_ack, 0);
    end
    check(add_z_ack == 1'b0, "t5_zack_dropped", add_z_ack, 0);
    ack_delay = 0;
    wait_idle("t5_done");
    slow_z = 1;
    post(2, rnd_op(), rnd_op());
    n = 0;
    while (!(busy && !add_a_stb && !add_b_stb && !add_z_ack && resp_stb == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(n < 200, "t6_wait_z_timeout", n, 200);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check(busy == 1'b0, "t6_idle", busy, 0);
    check(resp_stb == 0, "t6_no_resp", resp_stb, 0);
    rst = 1'b1;
    slow_z = 0;
    repeat (5) begin
      @(negedge clk);
      check(resp_stb == 0, "t6_quiet", resp_stb, 0);
    end
    post(3, ONE, ONE);
    wait_idle("t6_next");
    noise = 1;
    ack_delay = -1;
    repeat (30) begin
      n = $urandom_range(1, (1 << N) - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < N; i++) if (n[i]) post(i, rnd_op(), rnd_op());
      wait_idle("rand_done");
    end
    check(exp_q.size() == 0, "final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
